// File: rtl/key_entry_ctrl_pkg.sv
// Shared types and defaults for the serial keypad code-entry controller.
package key_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 50000000;
  localparam int DEF_TW      = 26;

endpackage

// File: rtl/key_entry_ctrl_if.sv
// Button levels in, code word and status out; state is exported for observation.
interface key_entry_if #(
  parameter int WIDTH = 4
);
  import key_entry_ctrl_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  // No back-pressure: valid is a one-cycle qualifier on dataout, consumer must take it then.
  logic            ln0;
  logic            ln1;
  logic            lnclr;
  logic [WIDTH-1:0] dataout;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            valid;
  logic            err;
  logic            tout;
  state_e          state;

  modport master (
    output ln0, ln1, lnclr,
    input  dataout, cnt, full, valid, err, tout, state
  );

  modport slave (
    input  ln0, ln1, lnclr,
    output dataout, cnt, full, valid, err, tout, state
  );

endinterface

// File: rtl/key_entry_ctrl_edge.sv
// Two-flop synchronizer followed by a registered rising-edge one-shot.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic ln,
  output logic pulse
);

  logic l_q;
  logic ll_q;
  logic pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_q     <= 1'b0;
      ll_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      l_q     <= ln;
      ll_q    <= l_q;
      pulse_q <= l_q & ~ll_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// Serial code entry: press detection, shift register, bit count, arbitration and idle timeout.
module key_entry_ctrl
  import key_entry_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TW      = DEF_TW
) (
  input  logic        clk,
  input  logic        reset,
  key_entry_if.slave  bus
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [TW-1:0]   TO_LAST  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic p0, p1, pc;

  key_edge u_edge0   (.clk(clk), .reset(reset), .ln(bus.ln0),   .pulse(p0));
  key_edge u_edge1   (.clk(clk), .reset(reset), .ln(bus.ln1),   .pulse(p1));
  key_edge u_edge_clr(.clk(clk), .reset(reset), .ln(bus.lnclr), .pulse(pc));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic             tout_q,  tout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    tout_d  = 1'b0;

    if (pc) begin
      state_d = ST_IDLE;
      data_d  = '0;
      cnt_d   = '0;
      timer_d = '0;
    end else if (p0 && p1) begin
      // A rejected press is not activity; the timer keeps running but stays saturated.
      err_d = 1'b1;
      if (TO_EN && (state_q == ST_COLLECT) && (timer_q < TO_LAST)) begin
        timer_d = timer_q + TW'(1);
      end
    end else if (p0 || p1) begin
      timer_d = '0;
      if (state_q == ST_FULL) begin
        data_d  = {p1, {(WIDTH-1){1'b0}}};
        cnt_d   = CW'(1);
        state_d = ST_COLLECT;
      end else begin
        data_d = {p1, data_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FULL;
          valid_d = 1'b1;
        end else begin
          state_d = ST_COLLECT;
        end
      end
    end else if (TO_EN && (state_q == ST_COLLECT)) begin
      if (timer_q >= TO_LAST) begin
        state_d = ST_IDLE;
        data_d  = '0;
        cnt_d   = '0;
        timer_d = '0;
        tout_d  = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  assign bus.dataout = data_q;
  assign bus.cnt     = cnt_q;
  assign bus.full    = (state_q == ST_FULL);
  assign bus.valid   = valid_q;
  assign bus.err     = err_q;
  assign bus.tout    = tout_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl with a press-history model and a completed-word scoreboard.
module tb_key_entry_ctrl;

  localparam int W   = 4;
  localparam int T   = 20;
  localparam int TWB = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  key_entry_if #(.WIDTH(W)) bus();

  key_entry_ctrl #(.WIDTH(W), .TIMEOUT(T), .TW(TWB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  // Button level histories: index k holds the level sampled k edges ago.
  bit             h0[1:3];
  bit             h1[1:3];
  bit             hc[1:3];
  bit             bits_q[$];
  int             idle = 0;
  logic           m_valid = 1'b0;
  logic           m_err   = 1'b0;
  logic           m_tout  = 1'b0;
  logic [W-1:0]   exp_q[$];

  // Accepted bits in order; the newest sits at the MSB, older ones below it.
  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    int n;
    w = '0;
    n = bits_q.size();
    for (int i = 0; i < n; i++) w[W-n+i] = bits_q[i];
    return w;
  endfunction

  initial forever begin
    bit pr0, pr1, prc;
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int k = 1; k <= 3; k++) begin h0[k] = 0; h1[k] = 0; hc[k] = 0; end
      bits_q.delete();
      exp_q.delete();
      idle = 0;
      m_valid = 0; m_err = 0; m_tout = 0;
    end else begin
      m_valid = 0; m_err = 0; m_tout = 0;
      pr0 = h0[2] & ~h0[3];
      pr1 = h1[2] & ~h1[3];
      prc = hc[2] & ~hc[3];
      h0[3] = h0[2]; h0[2] = h0[1]; h0[1] = bus.ln0;
      h1[3] = h1[2]; h1[2] = h1[1]; h1[1] = bus.ln1;
      hc[3] = hc[2]; hc[2] = hc[1]; hc[1] = bus.lnclr;
      if (prc) begin
        bits_q.delete();
        idle = 0;
      end else if (pr0 && pr1) begin
        m_err = 1;
        if (bits_q.size() > 0 && bits_q.size() < W && idle < T - 1) idle++;
      end else if (pr0 || pr1) begin
        if (bits_q.size() == W) bits_q.delete();
        bits_q.push_back(pr1);
        idle = 0;
        if (bits_q.size() == W) begin
          m_valid = 1;
          exp_q.push_back(model_word());
        end
      end else if (bits_q.size() > 0 && bits_q.size() < W) begin
        if (idle == T - 1) begin
          bits_q.delete();
          idle = 0;
          m_tout = 1;
        end else begin
          idle++;
        end
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      chk("dataout", bus.dataout, model_word());
      chk("cnt", bus.cnt, bits_q.size());
      chk("full", bus.full, bits_q.size() == W);
      chk("valid", bus.valid, m_valid);
      chk("err", bus.err, m_err);
      chk("tout", bus.tout, m_tout);
      if (bus.valid) begin
        chk("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("sb_word", bus.dataout, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_to(input int unsigned t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // b: 0 -> "0" button, 1 -> "1" button, 2 -> clear
  task automatic press(input int b);
    @(negedge clk);
    if (b == 0) bus.ln0 = 1'b1; else if (b == 1) bus.ln1 = 1'b1; else bus.lnclr = 1'b1;
    repeat (5) @(negedge clk);
    bus.ln0 = 1'b0; bus.ln1 = 1'b0; bus.lnclr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int unsigned s, a;
    bus.ln0 = 1'b0; bus.ln1 = 1'b0; bus.lnclr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dataout", bus.dataout, 0);
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_valid", bus.valid, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // "1", "0", "1", then the completing "1" with exact valid timing
    press(1); press(0); press(1);
    chk("three_bits", bus.dataout, 4'b1010);
    @(negedge clk); bus.ln1 = 1'b1; s = cyc + 1;
    wait_to(s + 1); chk("valid_early", bus.valid, 0);
    wait_to(s + 2);
    chk("valid_on", bus.valid, 1);
    chk("word_1101", bus.dataout, 4'b1101);
    chk("cnt_full", bus.cnt, 4);
    chk("full_on", bus.full, 1);
    wait_to(s + 3); chk("valid_off", bus.valid, 0);
    @(negedge clk); bus.ln1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("full_hold", bus.dataout, 4'b1101);

    // press "0" while FULL restarts the entry
    press(0);
    chk("restart_data", bus.dataout, 4'b0000);
    chk("restart_cnt", bus.cnt, 1);
    chk("restart_full", bus.full, 0);

    // both bit buttons on the same edge at cnt = 1
    @(negedge clk); bus.ln0 = 1'b1; bus.ln1 = 1'b1; s = cyc + 1;
    wait_to(s + 2);
    chk("both_err", bus.err, 1);
    chk("both_data", bus.dataout, 4'b0000);
    chk("both_cnt", bus.cnt, 1);
    wait_to(s + 3); chk("both_err_off", bus.err, 0);
    @(negedge clk); bus.ln0 = 1'b0; bus.ln1 = 1'b0;
    press(2);

    // one long hold gives exactly one shift
    @(negedge clk); bus.ln1 = 1'b1; s = cyc + 1;
    wait_to(s + 4);
    chk("hold_cnt", bus.cnt, 1);
    chk("hold_data", bus.dataout, 4'b1000);
    wait_to(s + 100);
    @(negedge clk); bus.ln1 = 1'b0;
    repeat (3) @(negedge clk);

    // clear mid-entry
    press(1); press(0);
    chk("mid_cnt", bus.cnt, 2);
    chk("mid_data", bus.dataout, 4'b0100);
    press(2);
    chk("clr_data", bus.dataout, 0);
    chk("clr_cnt", bus.cnt, 0);

    // clear together with "1": clear wins
    press(1);
    @(negedge clk); bus.lnclr = 1'b1; bus.ln1 = 1'b1; s = cyc + 1;
    wait_to(s + 2);
    chk("clr1_data", bus.dataout, 0);
    chk("clr1_cnt", bus.cnt, 0);
    chk("clr1_err", bus.err, 0);
    @(negedge clk); bus.lnclr = 1'b0; bus.ln1 = 1'b0;
    repeat (4) @(negedge clk);

    // timeout 20 cycles after the accepted press
    @(negedge clk); bus.ln1 = 1'b1; s = cyc + 1; a = s + 2;
    wait_to(a); chk("to_start_cnt", bus.cnt, 1);
    @(negedge clk); bus.ln1 = 1'b0;
    wait_to(a + 19); chk("to_not_yet", bus.tout, 0);
    wait_to(a + 20);
    chk("to_pulse", bus.tout, 1);
    chk("to_cnt", bus.cnt, 0);
    chk("to_data", bus.dataout, 0);
    wait_to(a + 21); chk("to_pulse_off", bus.tout, 0);

    // press landing on the expiry cycle wins
    @(negedge clk); bus.ln1 = 1'b1; s = cyc + 1; a = s + 2;
    wait_to(a); chk("race_start_cnt", bus.cnt, 1);
    @(negedge clk); bus.ln1 = 1'b0;
    wait_to(a + 17);
    @(negedge clk); bus.ln0 = 1'b1;
    wait_to(a + 20);
    chk("race_no_tout", bus.tout, 0);
    chk("race_cnt", bus.cnt, 2);
    chk("race_data", bus.dataout, 4'b0100);
    @(negedge clk); bus.ln0 = 1'b0;
    press(2);

    // asynchronous reset between edges at cnt = 3
    press(1); press(1); press(1);
    chk("pre_rst_cnt", bus.cnt, 3);
    chk("pre_rst_data", bus.dataout, 4'b1110);
    @(posedge clk); #3; reset = 1'b1; #1;
    chk("async_data", bus.dataout, 0);
    chk("async_cnt", bus.cnt, 0);
    chk("async_full", bus.full, 0);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
